// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-enable divider, DrawX/DrawY counters, delayed sync/blank, line/frame strobes.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_count output used for sprite animation.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_clk_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;
  // PIPE_DELAY=0 still needs one register, fed from the next count instead of the current one
  localparam int STAGES  = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..4");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  logic [2:0] div_cnt, div_nxt;
  logic [9:0] hc, vc, hc_nxt, vc_nxt;
  logic       h_wrap, v_wrap;
  logic [2:0] raw_src;
  logic [STAGES-1:0][2:0] dly;

  // {hs, vs, blank} for a given raster position
  function automatic logic [2:0] raw_of(input logic [9:0] x, input logic [9:0] y);
    raw_of = {!(x >= 10'(HS_BEG) && x <= 10'(HS_END)),
              !(y >= 10'(VS_BEG) && y <= 10'(VS_END)),
              (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE))};
  endfunction

  always_comb begin
    div_nxt = (div_cnt == 3'(CLK_DIV - 1)) ? 3'd0 : div_cnt + 3'd1;
    h_wrap  = (hc == 10'(H_TOTAL - 1));
    v_wrap  = (vc == 10'(V_TOTAL - 1));
    hc_nxt  = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt  = vc;
    if (h_wrap) vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
    raw_src = (PIPE_DELAY == 0) ? raw_of(hc_nxt, vc_nxt) : raw_of(hc, vc);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_cnt      <= '0;
      pixel_clk_en <= 1'b0;
      hc           <= '0;
      vc           <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      pixel_clk_en <= (div_nxt == 3'(CLK_DIV - 1));
      line_start   <= pixel_clk_en && h_wrap;
      frame_start  <= pixel_clk_en && h_wrap && v_wrap;
      if (pixel_clk_en) begin
        hc <= hc_nxt;
        vc <= vc_nxt;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      dly <= {STAGES{3'b110}};
    end else if (pixel_clk_en) begin
      dly[0] <= raw_src;
      for (int s = 1; s < STAGES; s++) dly[s] <= dly[s-1];
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge Clk) begin
    if (!Reset)                               frame_count <= '0;
    else if (pixel_clk_en && h_wrap && v_wrap) frame_count <= frame_count + 8'd1;
  end
`endif

  assign {hs, vs, blank} = dly[STAGES-1];
  assign DrawX = hc;
  assign DrawY = vc;
  assign sync  = 1'b0;

endmodule
